multi_cycle_processor: RTL
==========================

MULTI_CYCLE_PROCESSOR -- requirements
Module: multi_cycle_processor

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly:
- XLEN, 64, datapath and register width; legal values 32 or 64.
- RESET_PC, 0, PC value loaded on reset.
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly:
- clock, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- mem_req, out, 1, memory request valid.
- mem_we, out, 1, 1 = store, 0 = read (fetch or load).
- mem_addr, out, XLEN, byte address.
- mem_wdata, out, XLEN, store data.
- mem_ready, in, 1, request accepted/completed this cycle.
- mem_rdata, in, XLEN, read data, valid when mem_ready=1; fetch uses [31:0].
- retire, out, 1, one-cycle pulse per completed instruction.
- halted, out, 1, core stopped (see Configuration).

Function
REQ-003 Control SHALL be an FSM with states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-004 The supported instruction subset SHALL be:
- R-type add, sub, and, or, xor, slt, sltu.
- addi.
- Load: ld if XLEN=64, lw if XLEN=32.
- Store: sd if XLEN=64, sw if XLEN=32.
- beq, bne, jal.
REQ-005 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready=1, latch mem_rdata[31:0] into IR and go to DECODE.
REQ-006 DECODE: read rs1 and rs2 into operand registers, sign-extend the I/S/B/J immediate, go to EXECUTE.
REQ-007 EXECUTE behaviour SHALL be:
- R-type and addi: latch the ALU result, go to WRITEBACK.
- Load and store: latch rs1+imm as address, go to MEMORY.
- beq/bne: PC <= taken ? PC+imm : PC+4; pulse retire; go to FETCH.
- jal: latch PC+4 as result, PC <= PC+imm, go to WRITEBACK.
REQ-008 MEMORY: mem_req=1, mem_addr=latched address, mem_we=1 for store with mem_wdata=rs2.
- Store: on mem_ready, PC <= PC+4, pulse retire, go to FETCH.
- Load: on mem_ready, latch mem_rdata, go to WRITEBACK.
REQ-009 WRITEBACK: write rd (ignored when rd=0); PC <= PC+4 unless jal; pulse retire; go to FETCH.
REQ-010 While mem_ready=0 in FETCH or MEMORY, the FSM SHALL hold state, and mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable.
REQ-011 mem_req SHALL be 0 in DECODE, EXECUTE, WRITEBACK and HALT.
REQ-012 Register x0 SHALL always read 0.
REQ-013 Arithmetic SHALL wrap modulo 2^XLEN; slt compares signed, sltu unsigned.
REQ-014 PC SHALL wrap modulo 2^XLEN.
REQ-015 With zero-wait memory, latency in cycles SHALL be:
- ALU op, addi, jal: 4.
- Load: 5.
- Store: 4.
- Branch: 3.
Each wait cycle adds 1.
REQ-016 retire SHALL be high for exactly one cycle per instruction, in its final state.

Reset
REQ-017 While reset=0, the core SHALL hold the following values, applied asynchronously:
- State = FETCH, PC = RESET_PC, IR = 0.
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- retire = 0, halted = 0.
- All registers = 0.
REQ-018 The first mem_req=1 SHALL occur in the first cycle after reset deasserts.
REQ-019 Reset asserted mid-request SHALL abandon the access; a mem_ready arriving during reset SHALL be ignored.

Configuration
REQ-020 Macro ILLEGAL_HALT_EN SHALL select how unsupported opcodes/funct combinations are handled.
- Defined: EXECUTE goes to HALT, halted=1, retire stays 0, no state changes; HALT is left only by reset.
- Undefined: the instruction executes as a NOP (PC <= PC+4, retire pulses); HALT is unreachable and halted is tied 0.

Verification
REQ-021 Benches SHALL cover these directed scenarios:
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2 (zero-wait) -> x3=2, retire every 4 cycles, 12 cycles total.
- sd/sw x3 to address 0x100, then load into x4 -> store request we=1 addr=0x100 wdata=2; x4=2; load takes 5 cycles.
- beq x1,x1,+8 at PC=0x20 -> next fetch addr 0x28; bne x1,x1,+8 -> 0x24; 3 cycles each.
- mem_ready held 0 for 3 cycles during a fetch -> mem_req/mem_addr stable throughout; instruction completes 3 cycles later.
- addi x0,x0,7 then add x5,x0,x0 -> x5=0; reset pulled low mid-MEMORY -> mem_req=0 immediately, PC=RESET_PC.
- Opcode 0x7F: with ILLEGAL_HALT_EN -> halted=1 and no further mem_req; without it -> PC advances by 4 and retire pulses.

Source files
------------

// File: rtl/multi_cycle_processor.sv
// multi_cycle_processor: unpipelined RV-subset core.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK).
// One shared memory port serves both instruction fetches and data accesses.
// Optional build macro ILLEGAL_HALT_EN: an unsupported instruction parks the core in HALT
// (left only by reset). Without the macro, an unsupported instruction retires as a NOP.
//
// Memory handshake: mem_req marks a request. mem_ready=1 in the same cycle completes it,
// and for reads mem_rdata is valid in that cycle. While the core waits for mem_ready,
// mem_req, mem_we, mem_addr and mem_wdata are held stable.
module multi_cycle_processor #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            retire,
    output logic            halted
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ld/sd on a 64-bit core, lw/sw on a 32-bit core
    localparam logic [2:0]      F3_MEM = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;       // rs1 operand
    logic [XLEN-1:0] b_q, b_d;       // rs2 operand, also store data
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] res_q, res_d;   // value destined for rd
    logic [XLEN-1:0] addr_q, addr_d; // data access address
    logic [XLEN-1:0] rf_q [32];

    logic            rf_we;
    logic            retire_c;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;

    logic            is_rtype;
    logic            is_addi;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            br_taken;
    logic [XLEN-1:0] imm_sel;
    logic [XLEN-1:0] alu_res;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Classify the instruction held in IR; anything unmatched is unsupported
    always_comb begin
        is_rtype  = 1'b0;
        is_addi   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'h00) begin
                    is_rtype = funct3 inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
                end else if (funct7 == 7'h20) begin
                    is_rtype = (funct3 == 3'b000);
                end
            end
            OP_IMM:    is_addi   = (funct3 == 3'b000);
            OP_LOAD:   is_load   = (funct3 == F3_MEM);
            OP_STORE:  is_store  = (funct3 == F3_MEM);
            OP_BRANCH: is_branch = (funct3[2:1] == 2'b00);
            OP_JAL:    is_jal    = 1'b1;
            default:   ;
        endcase
    end

    // Sign-extended immediate in the format matching the opcode
    always_comb begin
        case (opcode)
            OP_STORE:  imm_sel = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH: imm_sel = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                  ir_q[11:8], 1'b0};
            OP_JAL:    imm_sel = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                                  ir_q[30:21], 1'b0};
            default:   imm_sel = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        endcase
    end

    // R-type ALU; funct7[5] separates sub from add
    always_comb begin
        case (funct3)
            3'b000:  alu_res = funct7[5] ? (a_q - b_q) : (a_q + b_q);
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            3'b100:  alu_res = a_q ^ b_q;
            3'b110:  alu_res = a_q | b_q;
            3'b111:  alu_res = a_q & b_q;
            default: alu_res = '0;
        endcase
    end

    // funct3[0] selects bne over beq
    assign br_taken = funct3[0] ? (a_q != b_q) : (a_q == b_q);

    // Next-state and datapath latch selection for the control FSM
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        res_d    = res_q;
        addr_d   = addr_q;
        rf_we    = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs1];
                b_d     = rf_q[rs2];
                imm_d   = imm_sel;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_rtype) begin
                    res_d   = alu_res;
                    state_d = S_WRITEBACK;
                end else if (is_addi) begin
                    res_d   = a_q + imm_q;
                    state_d = S_WRITEBACK;
                end else if (is_load || is_store) begin
                    addr_d  = a_q + imm_q;
                    state_d = S_MEMORY;
                end else if (is_branch) begin
                    pc_d     = br_taken ? (pc_q + imm_q) : (pc_q + FOUR);
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    res_d   = pc_q + FOUR;
                    pc_d    = pc_q + imm_q;
                    state_d = S_WRITEBACK;
                end else begin
`ifdef ILLEGAL_HALT_EN
                    state_d = S_HALT;
`else
                    pc_d     = pc_q + FOUR;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
`endif
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (is_store) begin
                        pc_d     = pc_q + FOUR;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                // jal already redirected PC in EXECUTE
                if (!is_jal) begin
                    pc_d = pc_q + FOUR;
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
        end
    end

    // Register file; x0 is never written so it always reads 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rd != 5'd0)) begin
            rf_q[rd] <= res_q;
        end
    end

    // Bus outputs decode from state and are forced idle while reset is low,
    // so an in-flight access drops immediately and the first fetch follows release
    assign mem_req   = reset && ((state_q == S_FETCH) || (state_q == S_MEMORY));
    assign mem_we    = reset && (state_q == S_MEMORY) && is_store;
    assign mem_addr  = !reset                ? '0 :
                       (state_q == S_FETCH)  ? pc_q :
                       (state_q == S_MEMORY) ? addr_q : '0;
    assign mem_wdata = mem_we ? b_q : '0;
    assign retire    = reset && retire_c;

`ifdef ILLEGAL_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
